// File: rtl/alu_stage_pkg.sv
// alu_stage_pkg: condition codes, flag bit positions, result entry layout and condition evaluation.
package alu_stage_pkg;
    localparam logic [2:0] COND_EQ     = 3'd0;
    localparam logic [2:0] COND_NE     = 3'd1;
    localparam logic [2:0] COND_LT     = 3'd2;
    localparam logic [2:0] COND_GE     = 3'd3;
    localparam logic [2:0] COND_LTU    = 3'd4;
    localparam logic [2:0] COND_GEU    = 3'd5;
    localparam logic [2:0] COND_ALWAYS = 3'd6;
    localparam logic [2:0] COND_SLT    = 3'd7;
    localparam int FLAG_OF = 3;
    localparam int FLAG_SF = 2;
    localparam int FLAG_ZF = 1;
    localparam int FLAG_CF = 0;
    localparam int ENTRY_RESULT_W = 32;
    localparam int ENTRY_RD_W     = 5;
    typedef struct packed {
        logic [ENTRY_RESULT_W-1:0] result;
        logic                      taken;
        logic [ENTRY_RD_W-1:0]     rd;
    } entry_t;
    // SLT produces a value, not a branch decision, so it never reports taken
    function automatic logic cond_taken(input logic [2:0] cond, input logic [3:0] flags);
        logic lt;
        lt = flags[FLAG_SF] ^ flags[FLAG_OF];
        return cond == COND_EQ     ?  flags[FLAG_ZF] :
               cond == COND_NE     ? !flags[FLAG_ZF] :
               cond == COND_LT     ?  lt :
               cond == COND_GE     ? !lt :
               cond == COND_LTU    ?  flags[FLAG_CF] :
               cond == COND_GEU    ? !flags[FLAG_CF] :
               cond == COND_ALWAYS;
    endfunction
endpackage

// File: rtl/alu_result_stage_skid_buf.sv
// skid_buf: 2-entry valid/ready buffer (main + skid) with registered in_ready.
module skid_buf #(
    parameter int PW = 38
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [PW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [PW-1:0] out_data_o
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] main_q, main_d, skid_q, skid_d;
    logic          in_ready_q, in_xfer, out_xfer;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = state_q != EMPTY;
    assign out_data_o  = main_q;
    assign in_xfer     = in_valid_i & in_ready_q;
    assign out_xfer    = out_valid_o & out_ready_i;
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (in_xfer) begin
                state_d = ONE;
                main_d  = in_data_i;
            end
            ONE: if (in_xfer && out_xfer) begin
                main_d = in_data_i;
            end else if (in_xfer) begin
                state_d = FULL;
                skid_d  = in_data_i;
            end else if (out_xfer) begin
                state_d = EMPTY;
            end
            FULL: if (out_xfer) begin
                state_d = ONE;
                main_d  = skid_q;
            end
            default: state_d = EMPTY;
        endcase
    end
    // in_ready is the registered complement of "skid occupied", so it never sees out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= state_d != FULL;
        end
    end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: condition evaluation, flag register and 2-entry skid buffer after the adder.
// Define ALU_RESULT_STAGE_STICKY_OF_EN to build the sticky-overflow register.
module alu_result_stage
    import alu_stage_pkg::*;
#(
    parameter int W    = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_f,
    input  logic [3:0]      in_flags,
    input  logic [2:0]      in_cond,
    input  logic            in_setf,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_result,
    output logic            out_taken,
    output logic [RD_W-1:0] out_rd,
    output logic [3:0]      flags_q,
    input  logic            clr_sticky,
    output logic            sticky_of
);
    localparam int PW = W + 1 + RD_W;
    logic          lt, taken, in_xfer;
    logic [W-1:0]  result;
    logic [PW-1:0] out_data;
    logic [3:0]    flags_d;
    assign lt      = in_flags[FLAG_SF] ^ in_flags[FLAG_OF];
    assign taken   = cond_taken(in_cond, in_flags);
    assign result  = in_cond == COND_SLT ? {{(W-1){1'b0}}, lt} : in_f;
    assign in_xfer = in_valid & in_ready;
    assign flags_d = in_xfer & in_setf ? in_flags : flags_q;
    skid_buf #(.PW(PW)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   ({result, taken, in_rd}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );
    assign {out_result, out_taken, out_rd} = out_data;
    // flags follow acceptance, not delivery, so a stalled output does not delay them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
    end
`ifdef ALU_RESULT_STAGE_STICKY_OF_EN
    logic sticky_q, sticky_d;
    assign sticky_d  = in_xfer & in_setf & in_flags[FLAG_OF] ? 1'b1 : clr_sticky ? 1'b0 : sticky_q;
    assign sticky_of = sticky_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign sticky_of = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and random stimulus against a queue-based reference model.
module tb_alu_result_stage;
    import alu_stage_pkg::*;
    logic        clk = 0, rst_n = 0, in_valid = 0, in_setf = 0, out_ready = 0, clr_sticky = 0;
    logic [31:0] in_f = 0;
    logic [3:0]  in_flags = 0;
    logic [2:0]  in_cond = 0;
    logic [4:0]  in_rd = 0;
    logic        in_ready, out_valid, out_taken, sticky_of;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [3:0]  flags_q;
    int          n_checks = 0, n_errors = 0;
    entry_t      mq[$];
    logic [3:0]  m_flags = 0;
    logic        m_sticky = 0;
    logic        acc;

    always #5 clk = ~clk;

    alu_result_stage #(.W(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f),
        .in_flags(in_flags), .in_cond(in_cond), .in_setf(in_setf), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_taken(out_taken), .out_rd(out_rd), .flags_q(flags_q),
        .clr_sticky(clr_sticky), .sticky_of(sticky_of)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic entry_t ref_entry(input logic [31:0] f, input logic [3:0] fl,
                                         input logic [2:0] c, input logic [4:0] rd);
        entry_t e;
        logic lt;
        lt = fl[2] != fl[3];
        case (c)
            3'd0: e.taken = fl[1];
            3'd1: e.taken = !fl[1];
            3'd2: e.taken = lt;
            3'd3: e.taken = !lt;
            3'd4: e.taken = fl[0];
            3'd5: e.taken = !fl[0];
            3'd6: e.taken = 1'b1;
            default: e.taken = 1'b0;
        endcase
        e.result = c == 3'd7 ? 32'(lt) : f;
        e.rd = rd;
        return e;
    endfunction

    task automatic check_all();
        check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("out_result", 64'(out_result), 64'(mq[0].result));
            check("out_taken", 64'(out_taken), 64'(mq[0].taken));
            check("out_rd", 64'(out_rd), 64'(mq[0].rd));
        end
        check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        check("flags_q", 64'(flags_q), 64'(m_flags));
        check("sticky_of", 64'(sticky_of), 64'(m_sticky));
    endtask

    task automatic step(input logic v, input logic [31:0] f, input logic [3:0] fl, input logic [2:0] c,
                        input logic s, input logic [4:0] rd, input logic ordy, input logic clr,
                        output logic a);
        logic pop;
        in_valid = v; in_f = f; in_flags = fl; in_cond = c; in_setf = s; in_rd = rd;
        out_ready = ordy; clr_sticky = clr;
        a   = v && mq.size() < 2;
        pop = mq.size() > 0 && ordy;
        if (a && s) m_flags = fl;
`ifdef ALU_RESULT_STAGE_STICKY_OF_EN
        if (a && s && fl[3]) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
`endif
        if (pop) void'(mq.pop_front());
        if (a) mq.push_back(ref_entry(f, fl, c, rd));
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drain();
        logic d;
        repeat (3) step(0, 0, 0, 0, 0, 0, 1, 0, d);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_out_result", 64'(out_result), 0);
        check("rst_out_taken", 64'(out_taken), 0);
        check("rst_out_rd", 64'(out_rd), 0);
        check("rst_flags", 64'(flags_q), 0);
        check("rst_sticky", 64'(sticky_of), 0);
        rst_n = 1;
        // zero result with ZF set, EQ
        step(1, 32'h0, 4'b0010, COND_EQ, 0, 5'd1, 1, 0, acc);
        check("eq_valid", 64'(out_valid), 1);
        check("eq_result", 64'(out_result), 0);
        check("eq_taken", 64'(out_taken), 1);
        // SLT with OF/SF variants
        step(1, 32'h1234, 4'b1000, COND_SLT, 0, 5'd2, 1, 0, acc);
        check("slt_lt_result", 64'(out_result), 1);
        check("slt_lt_taken", 64'(out_taken), 0);
        step(1, 32'h1234, 4'b1100, COND_SLT, 0, 5'd3, 1, 0, acc);
        check("slt_ge_result", 64'(out_result), 0);
        // LTU / GEU / ALWAYS
        step(1, 32'hA, 4'b0001, COND_LTU, 0, 5'd4, 1, 0, acc);
        check("ltu_taken", 64'(out_taken), 1);
        step(1, 32'hB, 4'b0001, COND_GEU, 0, 5'd5, 1, 0, acc);
        check("geu_taken", 64'(out_taken), 0);
        step(1, 32'hC, 4'b0000, COND_ALWAYS, 0, 5'd6, 1, 0, acc);
        check("always_taken", 64'(out_taken), 1);
        drain();
        // backpressure: A, B accepted, C held, then released in order
        step(1, 32'hAAAA, 4'b0000, COND_NE, 0, 5'd10, 0, 0, acc);
        check("a_accept", 64'(acc), 1);
        step(1, 32'hBBBB, 4'b0010, COND_NE, 0, 5'd11, 0, 0, acc);
        check("b_accept", 64'(acc), 1);
        check("in_ready_after_b", 64'(in_ready), 0);
        step(1, 32'hCCCC, 4'b0100, COND_LT, 0, 5'd12, 0, 0, acc);
        check("c_held", 64'(acc), 0);
        check("a_stable", 64'(out_result), 64'h0000AAAA);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'hCCCC, 4'b0100, COND_LT, 0, 5'd12, 1, 0, acc);
            if (acc) break;
        end
        check("c_accept", 64'(acc), 1);
        drain();
        // flags load while stalled; sticky set beats clear
        step(1, 32'h5, 4'b1001, COND_ALWAYS, 1, 5'd7, 0, 0, acc);
        check("setf_flags", 64'(flags_q), 64'h9);
        step(1, 32'h6, 4'b1000, COND_ALWAYS, 1, 5'd8, 0, 1, acc);
        check("setf_flags2", 64'(flags_q), 64'h8);
`ifdef ALU_RESULT_STAGE_STICKY_OF_EN
        check("sticky_set_wins", 64'(sticky_of), 1);
        step(0, 0, 0, 0, 0, 0, 1, 1, acc);
        check("sticky_cleared", 64'(sticky_of), 0);
`endif
        // reset while FULL
        step(1, 32'h77, 4'b0110, COND_EQ, 1, 5'd9, 0, 0, acc);
        check("full_in_ready", 64'(in_ready), 0);
        rst_n = 0;
        in_valid = 0;
        #1;
        mq.delete();
        m_flags = 0;
        m_sticky = 0;
        check("mid_rst_out_valid", 64'(out_valid), 0);
        check("mid_rst_in_ready", 64'(in_ready), 1);
        check("mid_rst_flags", 64'(flags_q), 0);
        @(negedge clk);
        rst_n = 1;
        step(1, 32'hCAFE, 4'b0000, COND_GE, 0, 5'd15, 1, 0, acc);
        check("post_rst_valid", 64'(out_valid), 1);
        check("post_rst_result", 64'(out_result), 64'hCAFE);
        // random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, $urandom, 4'($urandom), 3'($urandom), 1'($urandom),
                 5'($urandom), ($urandom % 4) != 0, ($urandom % 8) == 0, acc);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
